axis_config_writer: RTL and testbench
=====================================

Name: axis_config_writer

Overview:
- Initiator side of the 512-bit configuration bus (config_addr / config_data) consumed by the AXIS selector and other configurable RPSPMC blocks.
- Accepts a framed 32-bit AXI-Stream command stream from the PS, typically via a DMA or FIFO, and assembles up to 16 words into config_data.
- On a complete frame, presents the target address on config_addr for exactly one a_clk cycle.
- Outside that cycle, config_addr holds IDLE_ADDRESS, so no downstream block matches.

Parameters:
- IDLE_ADDRESS, 0: config_addr value when no commit is in progress; must never equal a real block address.
- MAX_WORDS, 16: maximum data words per frame, 16 x 32 = 512 bits.
- TIMEOUT_CYCLES, 1024: stall limit inside a frame; used only with CONFIG_WRITER_TIMEOUT_EN.

Ports:
- a_clk  in  1  system clock, 125 MHz.
- a_reset  in  1  reset.
- s_axis_tdata  in  32  command stream data.
- s_axis_tvalid  in  1  command stream valid.
- s_axis_tready  out  1  command stream ready.
- s_axis_tlast  in  1  marks last word of a frame.
- config_addr  out  32  target address; non-idle for exactly one cycle per commit.
- config_data  out  512  assembled configuration data; word i on bits [32*i+31 : 32*i].
- busy  out  1  high while a frame is open or a commit is in progress.
- commit_count  out  32  number of successful commits; wraps.
- error_count  out  16  number of aborted frames; saturates at 16'hFFFF.

Behaviour:
- Single clock a_clk; a_reset is asynchronous, active-high.
- Reset values: config_addr = IDLE_ADDRESS, config_data = 0, s_axis_tready = 0, busy = 0, commit_count = 0, error_count = 0.
  - s_axis_tready rises one cycle after a_reset deasserts.
- A beat is accepted when s_axis_tvalid and s_axis_tready are both high.
- Frame format:
  - Beat 0: target address A.
  - Beat 1: header; bits [4:0] give N, the data word count; bits [31:5] are ignored.
  - Beats 2 .. N+1: data words D0 .. D(N-1).
  - tlast must be set on beat N+1 and only there.
- Data words are assembled in a shadow register. Shadow words N..15 are zero, so a short frame clears the upper words.
- States: IDLE, HDR, DATA, COMMIT, DRAIN.
  - IDLE: tready = 1. Accepted beat latches A and moves to HDR.
    - If tlast is set on this beat: error, stay in IDLE.
    - If A == IDLE_ADDRESS: error, go to DRAIN.
  - HDR: accepted beat latches N, clears the shadow register and the word index, and moves to DATA.
    - If N == 0 or N > MAX_WORDS: error, go to DRAIN (or IDLE if tlast is set on this beat).
    - If tlast is set with a valid N: error, go to IDLE.
  - DATA: each accepted beat writes shadow[index], then index increments.
    - tlast on word N-1: go to COMMIT.
    - tlast before word N-1: error, go to IDLE, no commit.
    - Word N-1 without tlast: error, go to DRAIN.
  - COMMIT (exactly one cycle, tready = 0):
    - config_addr = A, config_data = shadow, both registered outputs that change in the same cycle.
    - commit_count increments.
    - Next cycle: config_addr returns to IDLE_ADDRESS and the state returns to IDLE.
  - DRAIN: tready = 1. Beats are discarded until a beat with tlast is accepted, then go to IDLE.
- Latency: last data word accepted in cycle k → config_addr = A in cycle k+1 → IDLE_ADDRESS and tready = 1 in cycle k+2.
- config_data holds its last committed value indefinitely. It changes only in COMMIT, never during frame assembly.
- Aborted frames never change config_addr or config_data. Each abort increments error_count once, saturating.
- busy = 1 in HDR, DATA, COMMIT and DRAIN.
- Reset asserted mid-frame or during COMMIT: immediate return to reset values; the partial frame is lost.
- Back-to-back frames: the address beat of the next frame may be accepted in cycle k+2.

Optional Feature:
- Macro: CONFIG_WRITER_TIMEOUT_EN.
- With the macro: a stall counter runs in HDR and DATA and clears on every accepted beat.
  - When it reaches TIMEOUT_CYCLES with no accepted beat, the frame aborts: go to IDLE, error_count increments, no commit.
  - The stall counter does not run in DRAIN.
- Without the macro: the block waits indefinitely in any state; TIMEOUT_CYCLES is unused.

Test Plan:
- Reset release, no traffic → config_addr = 0, config_data = 0, tready = 1 from the cycle after deassert, counters = 0.
- Frame A = 2000, N = 3, D = {0x00BA3210, 1, 5}, tlast on D2 → config_addr = 2000 for exactly one cycle at k+1; config_data[95:0] = {5, 1, 0x00BA3210}, upper bits 0; commit_count = 1.
- Frame A = 2000, N = 1, D0 = 0x123 after the previous frame → config_data[31:0] = 0x123, bits [511:32] = 0.
- Header N = 17, then 5 junk beats with tlast on the last → no commit, error_count = 1, config_data unchanged, back in IDLE.
- Frame N = 4 with tlast on the 2nd data word → abort, error_count increments; next valid frame commits normally.
- With CONFIG_WRITER_TIMEOUT_EN and TIMEOUT_CYCLES = 16: stop tvalid after 1 of 4 data words for 20 cycles → abort at stall cycle 16, error_count increments, config_addr never leaves 0.

Source files
------------

// File: rtl/axis_config_writer_if.sv
// rtl/axis_config_writer_if.sv - 32-bit command stream interface for the config writer
interface axis_config_writer_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_config_writer.sv
// rtl/axis_config_writer.sv - framed command stream to 512-bit config bus initiator (optional stall timeout: CONFIG_WRITER_TIMEOUT_EN)
module axis_config_writer #(
    parameter logic [31:0] IDLE_ADDRESS   = 32'd0,
    parameter int          MAX_WORDS      = 16,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                       a_clk,
    input  logic                       a_reset,
    axis_config_writer_if.slave        s_axis,
    output logic [31:0]                config_addr,
    output logic [32*MAX_WORDS-1:0]    config_data,
    output logic                       busy,
    output logic [31:0]                commit_count,
    output logic [15:0]                error_count
);

    typedef enum logic [2:0] {IDLE, HDR, DATA, COMMIT, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic                      ready_q, ready_d;
    logic [31:0]               addr_q, addr_d;
    logic [4:0]                n_q, n_d;
    logic [4:0]                idx_q, idx_d;
    logic [32*MAX_WORDS-1:0]   shadow_q, shadow_d;
    logic [31:0]               config_addr_q, config_addr_d;
    logic [32*MAX_WORDS-1:0]   config_data_q, config_data_d;
    logic [31:0]               commit_count_q, commit_count_d;
    logic [15:0]               error_count_q, error_count_d;
    logic                      tready_w;
    logic                      accept;
    logic                      err_inc;
    logic [4:0]                hdr_n;
`ifdef CONFIG_WRITER_TIMEOUT_EN
    logic [31:0]               stall_q, stall_d;
`endif

    // Ready is held low during reset, comes up on the first clock after release, and drops for the commit cycle.
    assign tready_w      = ready_q && (state_q != COMMIT);
    assign s_axis.tready = tready_w;
    assign config_addr   = config_addr_q;
    assign config_data   = config_data_q;
    assign busy          = (state_q != IDLE);
    assign commit_count  = commit_count_q;
    assign error_count   = error_count_q;
    assign hdr_n         = s_axis.tdata[4:0];

    // Frame parser: next state, shadow assembly, commit and error bookkeeping.
    always_comb begin
        state_d        = state_q;
        ready_d        = 1'b1;
        addr_d         = addr_q;
        n_d            = n_q;
        idx_d          = idx_q;
        shadow_d       = shadow_q;
        config_addr_d  = IDLE_ADDRESS;
        config_data_d  = config_data_q;
        commit_count_d = commit_count_q;
        err_inc        = 1'b0;
        accept         = s_axis.tvalid && tready_w;
`ifdef CONFIG_WRITER_TIMEOUT_EN
        stall_d        = '0;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d = s_axis.tdata;
                    if (s_axis.tlast) begin
                        err_inc = 1'b1;
                    end else if (s_axis.tdata == IDLE_ADDRESS) begin
                        err_inc = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        state_d = HDR;
                    end
                end
            end
            HDR: begin
                if (accept) begin
                    n_d      = hdr_n;
                    shadow_d = '0;
                    idx_d    = 5'd0;
                    if (hdr_n == 5'd0 || int'(hdr_n) > MAX_WORDS) begin
                        err_inc = 1'b1;
                        state_d = s_axis.tlast ? IDLE : DRAIN;
                    end else if (s_axis.tlast) begin
                        err_inc = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    if (int'(idx_q) < MAX_WORDS) begin
                        shadow_d[32*int'(idx_q) +: 32] = s_axis.tdata;
                    end
                    idx_d = idx_q + 5'd1;
                    if (idx_q == n_q - 5'd1) begin
                        if (s_axis.tlast) begin
                            // Address and data are registered together so they land in the same cycle.
                            state_d        = COMMIT;
                            config_addr_d  = addr_q;
                            config_data_d  = shadow_d;
                            commit_count_d = commit_count_q + 32'd1;
                        end else begin
                            err_inc = 1'b1;
                            state_d = DRAIN;
                        end
                    end else if (s_axis.tlast) begin
                        err_inc = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            DRAIN: begin
                if (accept && s_axis.tlast) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef CONFIG_WRITER_TIMEOUT_EN
        // Stall counter only runs while a frame is being assembled; any accepted beat clears it.
        if ((state_q == HDR || state_q == DATA) && !accept) begin
            stall_d = stall_q + 32'd1;
            if (stall_d == 32'(TIMEOUT_CYCLES)) begin
                stall_d = '0;
                err_inc = 1'b1;
                state_d = IDLE;
            end
        end
`endif

        error_count_d = (err_inc && error_count_q != 16'hFFFF) ? error_count_q + 16'd1 : error_count_q;
    end

    // State and datapath registers, all cleared asynchronously by a_reset.
    always_ff @(posedge a_clk or posedge a_reset) begin
        if (a_reset) begin
            state_q        <= IDLE;
            ready_q        <= 1'b0;
            addr_q         <= '0;
            n_q            <= '0;
            idx_q          <= '0;
            shadow_q       <= '0;
            config_addr_q  <= IDLE_ADDRESS;
            config_data_q  <= '0;
            commit_count_q <= '0;
            error_count_q  <= '0;
`ifdef CONFIG_WRITER_TIMEOUT_EN
            stall_q        <= '0;
`endif
        end else begin
            state_q        <= state_d;
            ready_q        <= ready_d;
            addr_q         <= addr_d;
            n_q            <= n_d;
            idx_q          <= idx_d;
            shadow_q       <= shadow_d;
            config_addr_q  <= config_addr_d;
            config_data_q  <= config_data_d;
            commit_count_q <= commit_count_d;
            error_count_q  <= error_count_d;
`ifdef CONFIG_WRITER_TIMEOUT_EN
            stall_q        <= stall_d;
`endif
        end
    end

endmodule

// File: tb/tb_axis_config_writer.sv
// tb/tb_axis_config_writer.sv - directed self-checking bench for axis_config_writer
`timescale 1ns/1ps
module tb_axis_config_writer;

    logic         a_clk;
    logic         a_reset;
    logic [31:0]  config_addr;
    logic [511:0] config_data;
    logic         busy;
    logic [31:0]  commit_count;
    logic [15:0]  error_count;

    int checks;
    int failures;
    int pulse_cycles;

    axis_config_writer_if s_axis_if ();

    axis_config_writer #(
        .IDLE_ADDRESS   (32'd0),
        .MAX_WORDS      (16),
`ifdef CONFIG_WRITER_TIMEOUT_EN
        .TIMEOUT_CYCLES (16)
`else
        .TIMEOUT_CYCLES (1024)
`endif
    ) dut (
        .a_clk        (a_clk),
        .a_reset      (a_reset),
        .s_axis       (s_axis_if.slave),
        .config_addr  (config_addr),
        .config_data  (config_data),
        .busy         (busy),
        .commit_count (commit_count),
        .error_count  (error_count)
    );

    initial a_clk = 1'b0;
    always #4 a_clk = ~a_clk;

    // Count every cycle in which the config bus shows a non-idle address.
    always @(negedge a_clk) begin
        if (!a_reset && config_addr != 32'd0) pulse_cycles++;
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one beat, wait (bounded) for acceptance; returns #1 after the accepting edge.
    task automatic send_beat(input logic [31:0] data, input logic last);
        int guard;
        s_axis_if.tdata  = data;
        s_axis_if.tlast  = last;
        s_axis_if.tvalid = 1'b1;
        guard = 0;
        @(negedge a_clk);
        while (!s_axis_if.tready && guard < 100) begin
            guard++;
            @(negedge a_clk);
        end
        if (guard >= 100) check("tready_timeout", 1, 0);
        @(posedge a_clk);
        #1;
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tlast  = 1'b0;
    endtask

    // Address, header, then n data words; tlast on beat index last_at (-1 for none).
    task automatic send_frame(input logic [31:0] a, input logic [31:0] hdr, input int n,
                              input logic [31:0] d [16], input int last_at);
        send_beat(a, last_at == 0);
        send_beat(hdr, last_at == 1);
        for (int i = 0; i < n; i++) send_beat(d[i], last_at == i + 2);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge a_clk);
        #1;
    endtask

    logic [31:0]  d [16];
    logic [511:0] exp_data;
    int           pulses_before;

    initial begin
        checks = 0;
        failures = 0;
        pulse_cycles = 0;
        s_axis_if.tdata  = '0;
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tlast  = 1'b0;
        for (int i = 0; i < 16; i++) d[i] = '0;

        // Reset values
        a_reset = 1'b1;
        #13;
        check("rst_addr",   config_addr, 0);
        check("rst_data",   config_data, 0);
        check("rst_tready", s_axis_if.tready, 0);
        check("rst_busy",   busy, 0);
        check("rst_commit", commit_count, 0);
        check("rst_error",  error_count, 0);
        @(negedge a_clk);
        a_reset = 1'b0;
        @(posedge a_clk);
        #1;
        check("tready_after_rst", s_axis_if.tready, 1);
        idle_cycles(3);
        check("idle_addr", config_addr, 0);

        // Frame A=2000 N=3
        d[0] = 32'h00BA3210; d[1] = 32'd1; d[2] = 32'd5;
        send_frame(32'd2000, 32'd3, 3, d, 4);
        exp_data = '0;
        exp_data[95:0] = {32'd5, 32'd1, 32'h00BA3210};
        check("f1_addr_k1",   config_addr, 32'd2000);
        check("f1_tready_k1", s_axis_if.tready, 0);
        check("f1_busy_k1",   busy, 1);
        check("f1_data",      config_data, exp_data);
        check("f1_commit",    commit_count, 1);
        idle_cycles(1);
        check("f1_addr_k2",   config_addr, 0);
        check("f1_tready_k2", s_axis_if.tready, 1);
        check("f1_busy_k2",   busy, 0);

        // Back-to-back short frame clears the upper words
        d[0] = 32'h123;
        send_frame(32'd2000, 32'd1, 1, d, 2);
        exp_data = '0;
        exp_data[31:0] = 32'h123;
        check("f2_addr",   config_addr, 32'd2000);
        check("f2_data",   config_data, exp_data);
        check("f2_commit", commit_count, 2);
        idle_cycles(1);
        check("f2_pulses", pulse_cycles, 2);

        // Header N=17 then junk drained up to tlast
        send_beat(32'd3000, 1'b0);
        send_beat(32'd17, 1'b0);
        check("n17_busy_drain", busy, 1);
        for (int i = 0; i < 5; i++) send_beat(32'hDEAD0000 + i, i == 4);
        idle_cycles(1);
        check("n17_error",  error_count, 1);
        check("n17_data",   config_data, exp_data);
        check("n17_busy",   busy, 0);
        check("n17_commit", commit_count, 2);
        check("n17_pulses", pulse_cycles, 2);

        // N=4 with tlast on second data word, then a good frame
        d[0] = 32'hA; d[1] = 32'hB;
        send_frame(32'd4000, 32'd4, 2, d, 3);
        idle_cycles(1);
        check("early_last_error", error_count, 2);
        check("early_last_busy",  busy, 0);
        check("early_last_data",  config_data, exp_data);
        d[0] = 32'hCAFE0001; d[1] = 32'hCAFE0002;
        send_frame(32'h55, 32'hFFFF_FFE2, 2, d, 3);
        exp_data = '0;
        exp_data[63:0] = {32'hCAFE0002, 32'hCAFE0001};
        check("recover_addr",   config_addr, 32'h55);
        check("recover_data",   config_data, exp_data);
        check("recover_commit", commit_count, 3);
        idle_cycles(1);

        // Address equal to IDLE_ADDRESS drains the frame
        send_beat(32'd0, 1'b0);
        check("idle_a_busy", busy, 1);
        send_beat(32'd2, 1'b0);
        send_beat(32'h77, 1'b1);
        idle_cycles(1);
        check("idle_a_error", error_count, 3);
        check("idle_a_busy2", busy, 0);

        // tlast on the address beat
        send_beat(32'd2000, 1'b1);
        check("addr_last_error", error_count, 4);
        check("addr_last_busy",  busy, 0);

        // Last data word without tlast goes to DRAIN
        d[0] = 32'h1; d[1] = 32'h2;
        send_frame(32'd2000, 32'd2, 2, d, -1);
        check("no_last_busy",  busy, 1);
        check("no_last_error", error_count, 5);
        send_beat(32'h9, 1'b1);
        idle_cycles(1);
        check("no_last_idle",   busy, 0);
        check("no_last_data",   config_data, exp_data);
        check("no_last_pulses", pulse_cycles, 3);

`ifdef CONFIG_WRITER_TIMEOUT_EN
        // Stall after one of four words: abort on the 16th stall cycle
        pulses_before = pulse_cycles;
        send_beat(32'd2000, 1'b0);
        send_beat(32'd4, 1'b0);
        send_beat(32'h1111, 1'b0);
        idle_cycles(15);
        check("to_busy_15",  busy, 1);
        check("to_error_15", error_count, 5);
        idle_cycles(1);
        check("to_busy_16",  busy, 0);
        check("to_error_16", error_count, 6);
        idle_cycles(4);
        check("to_pulses", pulse_cycles, pulses_before);
        check("to_data",   config_data, exp_data);
`endif

        // Reset asserted mid-frame
        send_beat(32'd2000, 1'b0);
        send_beat(32'd3, 1'b0);
        @(negedge a_clk);
        #1;
        a_reset = 1'b1;
        #1;
        check("mid_rst_busy",   busy, 0);
        check("mid_rst_tready", s_axis_if.tready, 0);
        check("mid_rst_data",   config_data, 0);
        check("mid_rst_commit", commit_count, 0);
        check("mid_rst_error",  error_count, 0);
        @(negedge a_clk);
        a_reset = 1'b0;
        idle_cycles(2);
        check("post_rst_tready", s_axis_if.tready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
